// File: rtl/rv_ctl_if.sv
// Control/datapath bundle for the multicycle RISC-V controller.
// The controller drives every strobe (master); the datapath supplies IR and zero (slave).
interface rv_ctl_if #(
    parameter int unsigned DPWIDTH  = 32,
    parameter int unsigned CNTWIDTH = 32
);
    logic [DPWIDTH-1:0]  instr;
    logic                zero;
    logic                pcsourse;
    logic                pcwrite;
    logic                pccen;
    logic                irwrite;
    logic [1:0]          wbsel;
    logic                regwen;
    logic [1:0]          immsel;
    logic [1:0]          asel;
    logic                bsel;
    logic [3:0]          alusel;
    logic                mdrwrite;
    logic                datawsel;
    logic                addrsel;
    logic                dmem_wen;
    logic                illegal;
    logic [CNTWIDTH-1:0] instret;

    modport master (
        input  instr, zero,
        output pcsourse, pcwrite, pccen, irwrite, wbsel, regwen, immsel, asel,
               bsel, alusel, mdrwrite, datawsel, addrsel, dmem_wen, illegal, instret
    );

    modport slave (
        output instr, zero,
        input  pcsourse, pcwrite, pccen, irwrite, wbsel, regwen, immsel, asel,
               bsel, alusel, mdrwrite, datawsel, addrsel, dmem_wen, illegal, instret
    );
endinterface

// File: rtl/rv_ctl.sv
// Multicycle control FSM for the RISC-V core (RV32I subset: OP, OP-IMM, LW, SW,
// BEQ, BNE, JAL, JALR). Unsupported encodings park the FSM in HALT until rst.
// Optional macro RV_CTL_INSTRET_EN adds a retired-instruction counter on instret.
module rv_ctl #(
    parameter int unsigned DPWIDTH  = 32,
    parameter int unsigned CNTWIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    rv_ctl_if.master bus
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    localparam logic [1:0] IMM_J = 2'd0;
    localparam logic [1:0] IMM_B = 2'd1;
    localparam logic [1:0] IMM_S = 2'd2;
    localparam logic [1:0] IMM_I = 2'd3;

    localparam logic [1:0] WB_MDR = 2'd0;
    localparam logic [1:0] WB_ALU = 2'd1;
    localparam logic [1:0] WB_PC  = 2'd2;

    localparam logic [1:0] A_REG = 2'd0;
    localparam logic [1:0] A_PCC = 2'd2;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXR, S_EXI, S_ALUWB, S_MADDR, S_MRD,
        S_LWB, S_MWR, S_BR, S_JAL, S_JALR1, S_JALR2, S_HALT
    } state_t;

    state_t     state, state_nxt;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       alt;
    logic       unused_instr;

    logic       pcsourse_c, pcwrite_c, pccen_c, irwrite_c, regwen_c, bsel_c;
    logic       mdrwrite_c, datawsel_c, addrsel_c, dmem_wen_c, illegal_c;
    logic [1:0] wbsel_c, immsel_c, asel_c;
    logic [3:0] alusel_c;

    assign opcode       = bus.instr[6:0];
    assign funct3       = bus.instr[14:12];
    assign alt          = bus.instr[30];
    assign unused_instr = ^{bus.instr[DPWIDTH-1:31], bus.instr[29:15], bus.instr[11:7]};

    // ALU operation from funct3; SUB only exists for register-register ops
    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic f7b5, input logic is_r);
        logic [3:0] op;
        case (f3)
            3'b000:  op = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // State register; reset returns to FETCH at any point in an instruction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_FETCH;
        else     state <= state_nxt;
    end

    // Next-state and control-strobe decode
    always_comb begin
        state_nxt  = state;
        pcsourse_c = 1'b0;
        pcwrite_c  = 1'b0;
        pccen_c    = 1'b0;
        irwrite_c  = 1'b0;
        wbsel_c    = WB_ALU;
        regwen_c   = 1'b0;
        immsel_c   = IMM_I;
        asel_c     = A_REG;
        bsel_c     = 1'b0;
        alusel_c   = ALU_ADD;
        mdrwrite_c = 1'b0;
        datawsel_c = 1'b0;
        addrsel_c  = 1'b0;
        dmem_wen_c = 1'b0;
        illegal_c  = 1'b0;

        case (state)
            S_FETCH: begin
                irwrite_c = 1'b1;
                pccen_c   = 1'b1;
                pcwrite_c = 1'b1;
                state_nxt = S_DECODE;
            end
            S_DECODE: begin
                // Precompute PC-relative jump/branch target into ALUOUT
                asel_c   = A_PCC;
                bsel_c   = 1'b1;
                immsel_c = (opcode == OP_JAL) ? IMM_J : IMM_B;
                case (opcode)
                    OP_R:     state_nxt = S_EXR;
                    OP_I:     state_nxt = S_EXI;
                    OP_LOAD:  state_nxt = (funct3 == 3'b010) ? S_MADDR : S_HALT;
                    OP_STORE: state_nxt = (funct3 == 3'b010) ? S_MADDR : S_HALT;
                    OP_BR:    state_nxt = (funct3[2:1] == 2'b00) ? S_BR : S_HALT;
                    OP_JAL:   state_nxt = S_JAL;
                    OP_JALR:  state_nxt = S_JALR1;
                    default:  state_nxt = S_HALT;
                endcase
            end
            S_EXR: begin
                alusel_c  = alu_op(funct3, alt, 1'b1);
                state_nxt = S_ALUWB;
            end
            S_EXI: begin
                bsel_c    = 1'b1;
                alusel_c  = alu_op(funct3, alt, 1'b0);
                state_nxt = S_ALUWB;
            end
            S_ALUWB: begin
                regwen_c  = 1'b1;
                state_nxt = S_FETCH;
            end
            S_MADDR: begin
                bsel_c    = 1'b1;
                immsel_c  = (opcode == OP_STORE) ? IMM_S : IMM_I;
                state_nxt = (opcode == OP_STORE) ? S_MWR : S_MRD;
            end
            S_MRD: begin
                mdrwrite_c = 1'b1;
                state_nxt  = S_LWB;
            end
            S_LWB: begin
                regwen_c  = 1'b1;
                wbsel_c   = WB_MDR;
                state_nxt = S_FETCH;
            end
            S_MWR: begin
                dmem_wen_c = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_BR: begin
                // funct3[0] selects BNE: take branch when zero differs from it
                alusel_c   = ALU_SUB;
                pcsourse_c = 1'b1;
                pcwrite_c  = bus.zero ^ funct3[0];
                state_nxt  = S_FETCH;
            end
            S_JAL, S_JALR2: begin
                // PC already holds PC+4, so it is the link value
                regwen_c   = 1'b1;
                wbsel_c    = WB_PC;
                pcwrite_c  = 1'b1;
                pcsourse_c = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_JALR1: begin
                bsel_c    = 1'b1;
                state_nxt = S_JALR2;
            end
            S_HALT: begin
                illegal_c = 1'b1;
                state_nxt = S_HALT;
            end
            default: state_nxt = S_HALT;
        endcase
    end

    assign bus.pcsourse = pcsourse_c;
    assign bus.pcwrite  = pcwrite_c;
    assign bus.pccen    = pccen_c;
    assign bus.irwrite  = irwrite_c;
    assign bus.wbsel    = wbsel_c;
    assign bus.regwen   = regwen_c;
    assign bus.immsel   = immsel_c;
    assign bus.asel     = asel_c;
    assign bus.bsel     = bsel_c;
    assign bus.alusel   = alusel_c;
    assign bus.mdrwrite = mdrwrite_c;
    assign bus.datawsel = datawsel_c;
    assign bus.addrsel  = addrsel_c;
    assign bus.dmem_wen = dmem_wen_c;
    assign bus.illegal  = illegal_c;

`ifdef RV_CTL_INSTRET_EN
    logic [CNTWIDTH-1:0] instret_q;
    logic                retire_c;

    assign retire_c = (state == S_ALUWB) || (state == S_LWB) || (state == S_MWR) ||
                      (state == S_BR)    || (state == S_JAL) || (state == S_JALR2);

    // Retired-instruction counter, bumped on each instruction's last cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           instret_q <= '0;
        else if (retire_c) instret_q <= instret_q + CNTWIDTH'(1);
    end

    assign bus.instret = instret_q;
`else
    assign bus.instret = CNTWIDTH'(0);
`endif

endmodule

// File: tb/tb_rv_ctl.sv
// Directed bench for rv_ctl: walks each supported instruction through its
// states and compares the full control-strobe vector every cycle.
module tb_rv_ctl;

    localparam int unsigned DPWIDTH  = 32;
    localparam int unsigned CNTWIDTH = 32;
`ifdef RV_CTL_INSTRET_EN
    localparam bit INSTRET_ON = 1'b1;
`else
    localparam bit INSTRET_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   retired  = 0;

    rv_ctl_if #(.DPWIDTH(DPWIDTH), .CNTWIDTH(CNTWIDTH)) bus ();

    rv_ctl #(.DPWIDTH(DPWIDTH), .CNTWIDTH(CNTWIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // {pcsourse,pcwrite,pccen,irwrite,wbsel,regwen,immsel,asel,bsel,alusel,mdrwrite,datawsel,addrsel,dmem_wen,illegal}
    function automatic logic [20:0] obs();
        return {bus.pcsourse, bus.pcwrite, bus.pccen, bus.irwrite, bus.wbsel, bus.regwen,
                bus.immsel, bus.asel, bus.bsel, bus.alusel, bus.mdrwrite, bus.datawsel,
                bus.addrsel, bus.dmem_wen, bus.illegal};
    endfunction

    function automatic logic [20:0] mk(
        input logic pcs, input logic pcw, input logic pcc, input logic irw,
        input logic [1:0] wb, input logic rw, input logic [1:0] imm, input logic [1:0] a,
        input logic b, input logic [3:0] alu, input logic mdr, input logic dws,
        input logic ads, input logic dw, input logic ill);
        return {pcs, pcw, pcc, irw, wb, rw, imm, a, b, alu, mdr, dws, ads, dw, ill};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input string tag, input logic [20:0] exp);
        check(tag, 64'(obs()), 64'(exp));
        step();
    endtask

    task automatic chk_ret(input string tag);
        check(tag, 64'(bus.instret), INSTRET_ON ? 64'(retired) : 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        retired = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [20:0] f_st, d_b, d_j, wb_st, mrd, lwb, mwr, jmp, hlt;
        f_st  = mk(0,1,1,1, 2'd1,0, 2'd3, 2'd0, 0, 4'd0, 0,0,0,0,0);
        d_b   = mk(0,0,0,0, 2'd1,0, 2'd1, 2'd2, 1, 4'd0, 0,0,0,0,0);
        d_j   = mk(0,0,0,0, 2'd1,0, 2'd0, 2'd2, 1, 4'd0, 0,0,0,0,0);
        wb_st = mk(0,0,0,0, 2'd1,1, 2'd3, 2'd0, 0, 4'd0, 0,0,0,0,0);
        mrd   = mk(0,0,0,0, 2'd1,0, 2'd3, 2'd0, 0, 4'd0, 1,0,0,0,0);
        lwb   = mk(0,0,0,0, 2'd0,1, 2'd3, 2'd0, 0, 4'd0, 0,0,0,0,0);
        mwr   = mk(0,0,0,0, 2'd1,0, 2'd3, 2'd0, 0, 4'd0, 0,0,0,1,0);
        jmp   = mk(1,1,0,0, 2'd2,1, 2'd3, 2'd0, 0, 4'd0, 0,0,0,0,0);
        hlt   = mk(0,0,0,0, 2'd1,0, 2'd3, 2'd0, 0, 4'd0, 0,0,0,0,1);

        rst       = 1'b1;
        bus.instr = '0;
        bus.zero  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_fetch", 64'(obs()), 64'(f_st));
        check("rst_instret", 64'(bus.instret), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;

        // addi x1,x0,5
        bus.instr = 32'h00500093;
        cyc("addi_F", f_st);
        cyc("addi_D", d_b);
        cyc("addi_EXI", mk(0,0,0,0, 2'd1,0, 2'd3, 2'd0, 1, 4'd0, 0,0,0,0,0));
        cyc("addi_WB", wb_st);
        retired++;
        chk_ret("ret_addi");

        // sub x2,x1,x2
        bus.instr = 32'h40208133;
        cyc("sub_F", f_st);
        cyc("sub_D", d_b);
        cyc("sub_EXR", mk(0,0,0,0, 2'd1,0, 2'd3, 2'd0, 0, 4'd1, 0,0,0,0,0));
        cyc("sub_WB", wb_st);
        retired++;

        // srai x3,x1,2 -> SRA; srli x3,x1,2 -> SRL; addi with imm[10] set stays ADD
        bus.instr = 32'h4020d193;
        cyc("srai_F", f_st);
        cyc("srai_D", d_b);
        cyc("srai_EXI", mk(0,0,0,0, 2'd1,0, 2'd3, 2'd0, 1, 4'd7, 0,0,0,0,0));
        cyc("srai_WB", wb_st);
        retired++;
        bus.instr = 32'h0020d193;
        cyc("srli_F", f_st);
        cyc("srli_D", d_b);
        cyc("srli_EXI", mk(0,0,0,0, 2'd1,0, 2'd3, 2'd0, 1, 4'd6, 0,0,0,0,0));
        cyc("srli_WB", wb_st);
        retired++;
        bus.instr = 32'h40000093;
        cyc("addib30_F", f_st);
        cyc("addib30_D", d_b);
        cyc("addib30_EXI", mk(0,0,0,0, 2'd1,0, 2'd3, 2'd0, 1, 4'd0, 0,0,0,0,0));
        cyc("addib30_WB", wb_st);
        retired++;
        // and x4,x1,x2 (funct3 111)
        bus.instr = 32'h0020f233;
        cyc("and_F", f_st);
        cyc("and_D", d_b);
        cyc("and_EXR", mk(0,0,0,0, 2'd1,0, 2'd3, 2'd0, 0, 4'd9, 0,0,0,0,0));
        cyc("and_WB", wb_st);
        retired++;
        chk_ret("ret_alu");

        // lw x3,0(x1)
        bus.instr = 32'h0000a183;
        cyc("lw_F", f_st);
        cyc("lw_D", d_b);
        cyc("lw_MADDR", mk(0,0,0,0, 2'd1,0, 2'd3, 2'd0, 1, 4'd0, 0,0,0,0,0));
        cyc("lw_MRD", mrd);
        cyc("lw_LWB", lwb);
        retired++;

        // sw x3,0(x1): write strobe for exactly one cycle
        bus.instr = 32'h0030a023;
        cyc("sw_F", f_st);
        cyc("sw_D", d_b);
        cyc("sw_MADDR", mk(0,0,0,0, 2'd1,0, 2'd2, 2'd0, 1, 4'd0, 0,0,0,0,0));
        cyc("sw_MWR", mwr);
        retired++;
        chk_ret("ret_mem");

        // beq/bne with both zero values
        for (int k = 0; k < 4; k++) begin
            bus.instr = (k < 2) ? 32'h00208463 : 32'h00209463;
            bus.zero  = k[0];
            cyc("br_F", f_st);
            cyc("br_D", d_b);
            cyc($sformatf("br%0d_BR", k),
                mk(1, (k < 2) ? k[0] : ~k[0], 0,0, 2'd1,0, 2'd3, 2'd0, 0, 4'd1, 0,0,0,0,0));
            retired++;
        end
        bus.zero = 1'b0;
        chk_ret("ret_br");

        // jal x1,8
        bus.instr = 32'h008000ef;
        cyc("jal_F", f_st);
        cyc("jal_D", d_j);
        cyc("jal_JAL", jmp);
        retired++;
        check("jal_next_F", 64'(obs()), 64'(f_st));

        // jalr x1,0(x1)
        bus.instr = 32'h000080e7;
        cyc("jalr_F", f_st);
        cyc("jalr_D", d_b);
        cyc("jalr_J1", mk(0,0,0,0, 2'd1,0, 2'd3, 2'd0, 1, 4'd0, 0,0,0,0,0));
        cyc("jalr_J2", jmp);
        retired++;
        chk_ret("ret_jmp");

        // ecall halts; nothing enabled and no retirement while halted
        bus.instr = 32'h00000073;
        cyc("ecall_F", f_st);
        cyc("ecall_D", d_b);
        for (int i = 0; i < 20; i++) cyc($sformatf("halt_%0d", i), hlt);
        chk_ret("ret_halt");

        do_reset();
        check("halt_rst_F", 64'(obs()), 64'(f_st));
        chk_ret("ret_after_rst");

        // lb (funct3 000) is unsupported
        bus.instr = 32'h00008183;
        cyc("lb_F", f_st);
        cyc("lb_D", d_b);
        cyc("lb_HALT", hlt);
        check("lb_sticky", 64'(obs()), 64'(hlt));
        do_reset();

        // one retirement, then asynchronous reset in MRD of a load
        bus.instr = 32'h00500093;
        cyc("addi2_F", f_st);
        cyc("addi2_D", d_b);
        cyc("addi2_EXI", mk(0,0,0,0, 2'd1,0, 2'd3, 2'd0, 1, 4'd0, 0,0,0,0,0));
        cyc("addi2_WB", wb_st);
        retired++;
        chk_ret("ret_addi2");
        bus.instr = 32'h0000a183;
        cyc("lw2_F", f_st);
        cyc("lw2_D", d_b);
        cyc("lw2_MADDR", mk(0,0,0,0, 2'd1,0, 2'd3, 2'd0, 1, 4'd0, 0,0,0,0,0));
        check("lw2_MRD", 64'(obs()), 64'(mrd));
        #1;
        rst = 1'b1;
        #1;
        retired = 0;
        check("async_rst_F", 64'(obs()), 64'(f_st));
        check("async_rst_illegal", 64'(bus.illegal), 64'd0);
        check("async_rst_instret", 64'(bus.instret), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        cyc("post_rst_F", f_st);
        cyc("post_rst_D", d_b);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
